// File: rtl/bch_pkg.sv
// Shared BCH(15,7) constants and types for the decoder stream controller.
package bch_pkg;
  localparam int N = 15;
  localparam int K = 7;
  localparam int T = 2;
  localparam logic [8:0] G = 9'h1D1;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } sched_state_t;
endpackage

// File: rtl/bch_decode_sched_if.sv
// Codeword input stream, decoder-side bus and result output stream.
interface bch_decode_sched_if;
  logic                  in_valid;
  logic                  in_ready;
  logic [bch_pkg::N-1:0] in_codeword;
  logic [bch_pkg::N-1:0] dec_codeword;
  logic [bch_pkg::N-1:0] dec_corrected;
  logic [bch_pkg::N-1:0] dec_error_vector;
  logic                  dec_error_flag;
  logic                  out_valid;
  logic                  out_ready;
  logic [bch_pkg::N-1:0] out_codeword;
  logic [bch_pkg::K-1:0] out_data;
  logic [1:0]            out_status;
  logic [3:0]            out_nerr;

  modport slave (
    input  in_valid, in_codeword, dec_corrected, dec_error_vector, dec_error_flag, out_ready,
    output in_ready, dec_codeword, out_valid, out_codeword, out_data, out_status, out_nerr
  );

  modport master (
    output in_valid, in_codeword, dec_corrected, dec_error_vector, dec_error_flag, out_ready,
    input  in_ready, dec_codeword, out_valid, out_codeword, out_data, out_status, out_nerr
  );
endinterface

// File: rtl/bch_popcount15.sv
// Combinational population count of a 15-bit error vector.
module bch_popcount15 (
  input  logic [14:0] i_vec,
  output logic [3:0]  o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 15; i++) o_cnt = o_cnt + {3'b000, i_vec[i]};
  end
endmodule

// File: rtl/bch_decode_sched.sv
// Feeds one codeword at a time to the BCH(15,7) decoder, waits out its latency,
// classifies the result and returns it downstream with saturating statistics.
module bch_decode_sched
  import bch_pkg::*;
#(
  parameter int DEC_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  bch_decode_sched_if.slave bus,
  input  logic              stats_clr,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_total,
  output logic [CNT_W-1:0]  cnt_clean,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);
  localparam int WC_W = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;

  sched_state_t    r_state, w_next;
  logic [WC_W-1:0] r_wcnt;
  logic [N-1:0]    r_dec_cw, r_raw, r_out_cw, w_out_cw;
  status_t         r_out_status, w_status;
  logic [3:0]      r_out_nerr, w_nerr;
  logic            w_accept, w_capture, w_in_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  bch_popcount15 u_popcount (
    .i_vec (bus.dec_error_vector),
    .o_cnt (w_nerr)
  );

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_in_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wcnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_accept = 1'b1;
            w_next   = S_WAIT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // An uncorrectable result returns the word exactly as it was received.
  always_comb begin
    w_status = ST_UNCORR;
    if (!bus.dec_error_flag) w_status = ST_CLEAN;
    else if (w_nerr != 4'd0 && w_nerr <= 4'(T)) w_status = ST_CORR;
    w_out_cw = (w_status == ST_UNCORR) ? r_raw : bus.dec_corrected;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wcnt       <= '0;
      r_dec_cw     <= '0;
      r_raw        <= '0;
      r_out_cw     <= '0;
      r_out_status <= ST_CLEAN;
      r_out_nerr   <= '0;
    end else begin
      if (w_accept) begin
        r_dec_cw <= bus.in_codeword;
        r_raw    <= bus.in_codeword;
        r_wcnt   <= WC_W'(DEC_LATENCY - 1);
      end else if (r_state == S_WAIT && r_wcnt != '0) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
      if (w_capture) begin
        r_out_cw     <= w_out_cw;
        r_out_status <= w_status;
        r_out_nerr   <= w_nerr;
      end
    end
  end

  // A clear coinciding with a capture wins; that capture is not counted.
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      cnt_total  <= '0;
      cnt_clean  <= '0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (w_capture) begin
      cnt_total <= sat_inc(cnt_total);
      unique case (w_status)
        ST_CLEAN:  cnt_clean  <= sat_inc(cnt_clean);
        ST_CORR:   cnt_corr   <= sat_inc(cnt_corr);
        ST_UNCORR: cnt_uncorr <= sat_inc(cnt_uncorr);
        default:   ;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.dec_codeword = r_dec_cw;
  assign bus.out_valid    = (r_state == S_DONE);
  assign bus.out_codeword = r_out_cw;
  assign bus.out_data     = r_out_cw[N-1:N-K];
  assign bus.out_status   = r_out_status;
  assign bus.out_nerr     = r_out_nerr;
  assign busy             = (r_state != S_IDLE);
endmodule

// File: tb/tb_bch_decode_sched.sv
// Scoreboard bench for bch_decode_sched with a brute-force BCH(15,7) decoder model.
module tb_bch_decode_sched;
  import bch_pkg::*;

  localparam int L  = 4;
  localparam int CW = 7;

  typedef struct packed {
    logic [14:0] corr;
    logic [14:0] vec;
    logic        flag;
  } dec_t;

  typedef struct packed {
    logic [14:0] cw;
    logic [1:0]  st;
    logic [3:0]  nerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stats_clr = 1'b0;
  logic busy;
  logic [CW-1:0] cnt_total, cnt_clean, cnt_corr, cnt_uncorr;
  int stub_mode = 0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  bch_decode_sched_if bus ();

  bch_decode_sched #(.DEC_LATENCY(L), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stats_clr  (stats_clr),
    .busy       (busy),
    .cnt_total  (cnt_total),
    .cnt_clean  (cnt_clean),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rem8(input logic [14:0] v);
    logic [14:0] x;
    x = v;
    for (int i = 14; i >= 8; i--) if (x[i]) x = x ^ (15'(G) << (i - 8));
    return x[7:0];
  endfunction

  function automatic logic [14:0] enc(input logic [6:0] m);
    logic [14:0] s;
    s = {m, 8'h00};
    return s | {7'h00, rem8(s)};
  endfunction

  // mode 0: ideal t=2 decoder; 1: flag without error vector; 2: flag with a 3-bit vector
  function automatic dec_t decode(input logic [14:0] r, input int mode);
    dec_t d;
    logic [7:0] s;
    logic [14:0] e;
    d.corr = r; d.vec = '0; d.flag = 1'b0;
    if (mode == 1) begin d.corr = '0; d.flag = 1'b1; return d; end
    if (mode == 2) begin d.vec = 15'h0007; d.corr = r ^ d.vec; d.flag = 1'b1; return d; end
    s = rem8(r);
    if (s == 8'h00) return d;
    d.flag = 1'b1;
    for (int i = 0; i < 15; i++) begin
      for (int j = i; j < 15; j++) begin
        e = (15'h1 << i) | (15'h1 << j);
        if (rem8(e) == s) begin d.vec = e; d.corr = r ^ e; return d; end
      end
    end
    return d;
  endfunction

  function automatic exp_t expect_of(input logic [14:0] r, input int mode);
    exp_t x;
    dec_t d;
    int n;
    d = decode(r, mode);
    n = $countones(d.vec);
    x.nerr = 4'(n);
    if (!d.flag) x.st = 2'b00;
    else if (n >= 1 && n <= 2) x.st = 2'b01;
    else x.st = 2'b10;
    x.cw = (x.st == 2'b10) ? r : d.corr;
    return x;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Decoder model: outputs settle L-1 edges after its input changes.
  dec_t pipe [L-1];
  always @(posedge clk) begin
    pipe[0] <= decode(bus.dec_codeword, stub_mode);
    for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.dec_corrected    = pipe[L-2].corr;
  assign bus.dec_error_vector = pipe[L-2].vec;
  assign bus.dec_error_flag   = pipe[L-2].flag;

  exp_t sb [$];
  int   lat_q [$];
  logic [CW-1:0] m_total = '0, m_clean = '0, m_corr = '0, m_uncorr = '0;
  logic prev_rst = 1'b0, prev_clr = 1'b0, prev_ov = 1'b0;

  initial begin
    exp_t e;
    int a;
    forever begin
      @(negedge clk); #2;
      if (!prev_rst) begin
        sb.delete(); lat_q.delete();
        m_total = '0; m_clean = '0; m_corr = '0; m_uncorr = '0;
      end else begin
        if (prev_clr) begin m_total = '0; m_clean = '0; m_corr = '0; m_uncorr = '0; end
        if (bus.out_valid && !prev_ov) begin
          if (sb.size() == 0) check("unexpected_out", bus.out_valid, 1'b0);
          else begin
            if (lat_q.size() != 0) begin a = lat_q.pop_front(); check("latency", cyc - a, L); end
            if (!prev_clr) begin
              m_total = sat(m_total);
              case (sb[0].st)
                2'b00:   m_clean  = sat(m_clean);
                2'b01:   m_corr   = sat(m_corr);
                default: m_uncorr = sat(m_uncorr);
              endcase
            end
            check("cnt_total", cnt_total, m_total);
            check("cnt_clean", cnt_clean, m_clean);
            check("cnt_corr", cnt_corr, m_corr);
            check("cnt_uncorr", cnt_uncorr, m_uncorr);
          end
        end
      end
      if (rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("pop_empty", bus.out_valid, 1'b0);
        else begin
          e = sb.pop_front();
          check("out_codeword", bus.out_codeword, e.cw);
          check("out_data", bus.out_data, e.cw[14:8]);
          check("out_status", bus.out_status, e.st);
          check("out_nerr", bus.out_nerr, e.nerr);
        end
      end
      if (rst && bus.in_valid && bus.in_ready) begin
        sb.push_back(expect_of(bus.in_codeword, stub_mode));
        lat_q.push_back(cyc + 1);
      end
      prev_rst = rst; prev_clr = stats_clr; prev_ov = bus.out_valid;
    end
  end

  // All tasks start at a falling edge and return at a falling edge.
  task automatic send(input logic [14:0] w);
    int n;
    n = 0;
    bus.in_codeword = w;
    bus.in_valid    = 1'b1;
    #1;
    while (!bus.in_ready && n < 1000) begin @(negedge clk); #1; n++; end
    check("send_accept", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [14:0] cw, input logic [1:0] st,
                            input logic [3:0] nerr);
    int n;
    n = 0;
    #2;
    while (!bus.out_valid && n < 50) begin @(negedge clk); #2; n++; end
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_cw"}, bus.out_codeword, cw);
    check({tag, "_data"}, bus.out_data, cw[14:8]);
    check({tag, "_status"}, bus.out_status, st);
    check({tag, "_nerr"}, bus.out_nerr, nerr);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #2;
    while ((busy || sb.size() != 0) && n < 2000) begin @(negedge clk); #2; n++; end
    check("idle", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_cnts(input string tag, input int t, input int c, input int r, input int u);
    check({tag, "_total"}, cnt_total, t);
    check({tag, "_clean"}, cnt_clean, c);
    check({tag, "_corr"}, cnt_corr, r);
    check({tag, "_uncorr"}, cnt_uncorr, u);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_codeword = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_dec_cw", bus.dec_codeword, 15'h0);
    check("rst_out_cw", bus.out_codeword, 15'h0);
    check("rst_out_status", bus.out_status, 2'b00);
    check("rst_out_nerr", bus.out_nerr, 4'h0);
    check_cnts("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send(15'h01D1);
    expect_out("clean", 15'h01D1, 2'b00, 4'd0);
    wait_idle();
    check_cnts("clean", 1, 1, 0, 0);

    send(15'h01D5);
    expect_out("single", 15'h01D1, 2'b01, 4'd1);
    wait_idle();
    check("single_cnt_corr", cnt_corr, 1);

    send(15'h41D0);
    expect_out("double", 15'h01D1, 2'b01, 4'd2);
    wait_idle();

    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    stub_mode = 1;
    send(15'h7FFF);
    expect_out("stub_nerr0", 15'h7FFF, 2'b10, 4'd0);
    wait_idle();
    check_cnts("stub", 1, 0, 0, 1);
    stub_mode = 2;
    send(15'h01D1);
    expect_out("stub_nerr3", 15'h01D1, 2'b10, 4'd3);
    wait_idle();
    stub_mode = 0;

    // Backpressure: result held while downstream stalls, then same-edge hand-over.
    bus.out_ready = 1'b0;
    send(15'h01D5);
    begin
      int n;
      n = 0;
      #2;
      while (!bus.out_valid && n < 50) begin @(negedge clk); #2; n++; end
      check("bp_valid", bus.out_valid, 1'b1);
    end
    @(negedge clk);
    bus.in_codeword = 15'h41D0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_cw", bus.out_codeword, 15'h01D1);
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_dec_cw", bus.dec_codeword, 15'h01D5);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_out("b2b", 15'h01D1, 2'b01, 4'd2);
    wait_idle();

    // Clear asserted on the capture edge drops that increment.
    send(15'h01D1);
    repeat (L - 1) @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #2;
    check_cnts("clr_on_capture", 0, 0, 0, 0);
    @(negedge clk);
    wait_idle();

    for (int i = 0; i < 15; i++) begin
      for (int j = i + 1; j < 15; j++) begin
        send(enc(7'((i * 15 + j) * 3)) ^ (15'h1 << i) ^ (15'h1 << j));
      end
    end
    wait_idle();
    check_cnts("sweep", 105, 0, 105, 0);

    for (int k = 0; k < 30; k++) send(enc(7'($urandom_range(0, 127))));
    wait_idle();
    check_cnts("sat", 127, 30, 105, 0);

    // Reset while the decoder wait is in progress.
    send(15'h01D5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      check("rst_wait_no_valid", bus.out_valid, 1'b0);
      @(negedge clk);
    end
    #2;
    check("rst_wait_busy", busy, 1'b0);
    check_cnts("rst_wait", 0, 0, 0, 0);
    @(negedge clk);

    send(15'h01D5);
    expect_out("recover", 15'h01D1, 2'b01, 4'd1);
    wait_idle();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bch_decode_sched.md
Name: bch_decode_sched

Overview:
Stream-side controller for the BCH(15,7) decoder (syndrome → IBM → Chien chain).
- Accepts received 15-bit codewords over a valid/ready handshake and drives one word at a time into the decoder.
- Holds that word stable for the decoder latency, then captures the decoder outputs.
- Classifies each result, extracts the 7-bit message and returns it on a valid/ready output, keeping saturating decode statistics.

Parameters:
DEC_LATENCY, 4, clock edges from decoder input change to valid decoder outputs; legal range ≥1.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
in_valid  in  1  input codeword valid.
in_ready  out  1  controller can accept a codeword.
in_codeword  in  15  received word r(x), bit 14 = x^14.
dec_codeword  out  15  registered word driven to the decoder.
dec_corrected  in  15  decoder corrected_codeword.
dec_error_vector  in  15  decoder error_vector_out.
dec_error_flag  in  1  decoder error_flag.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_codeword  out  15  final codeword.
out_data  out  7  message, out_codeword[14:8] (systematic).
out_status  out  2  00 CLEAN, 01 CORRECTED, 10 UNCORRECTABLE, 11 unused.
out_nerr  out  4  popcount(dec_error_vector) at capture.
busy  out  1  FSM not in IDLE.
stats_clr  in  1  synchronous clear of all counters.
cnt_total, cnt_clean, cnt_corr, cnt_uncorr  out  CNT_W each  saturating counters.

Behaviour:
- Reset (rst=0 at an edge) values:
  - FSM=IDLE; dec_codeword=0; all out_* =0; all counters=0; busy=0.
  - Any in-flight word is dropped; no counter updates.
- FSM states: IDLE, WAIT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready.
- Accept at edge E0 (in_valid && in_ready):
  - dec_codeword <= in_codeword.
  - Latch a raw copy of the word.
  - wcnt <= DEC_LATENCY-1.
  - state <= WAIT.
- WAIT:
  - While wcnt≠0, decrement wcnt; dec_codeword stays stable.
  - At the edge where wcnt==0 (edge E0+DEC_LATENCY), capture the result and go to DONE.
  - out_valid is high from the cycle after the capture edge.
- Classification at capture:
  - nerr=popcount(dec_error_vector).
  - Flag 0 → CLEAN; out_codeword=dec_corrected.
  - Flag 1 and 1≤nerr≤2 → CORRECTED; out_codeword=dec_corrected.
  - Flag 1 and (nerr==0 or nerr>2) → UNCORRECTABLE; out_codeword=raw latched word, uncorrected.
- DONE:
  - out_* held stable while out_valid && !out_ready.
  - On out_ready, the result is consumed.
  - If in_valid is high on the same edge, the next word is accepted and the FSM goes to WAIT (back-to-back).
  - Otherwise the FSM goes to IDLE and out_valid drops.
  - Minimum throughput: one word per DEC_LATENCY+1 cycles.
- Counters:
  - At the capture edge, cnt_total and the counter matching the status each increment by 1.
  - Counters saturate at all-ones.
  - stats_clr zeroes all counters. If it coincides with a capture, the clear wins and that increment is lost.
- in_valid while busy and not in_ready: the word is not accepted; the upstream must hold it.
- rst during WAIT or DONE: immediate return to reset values; nothing is emitted.

Decomposition:
- Shared package bch_pkg:
  - N=15, K=7, T=2.
  - Enum status_t {ST_CLEAN, ST_CORR, ST_UNCORR}.
  - Enum sched_state_t.
  - Generator constant G=9'h1D1.
- One sub-module bch_popcount15: combinational 15→4 popcount.
- The controller instantiates no decoder. The bench or toplevel wires dec_* to bch_toplevel.

Test Plan:
- Clean word: in_codeword=15'h01D1 (msg 0x01) → out_valid 4 cycles after accept, out_codeword=15'h01D1, out_data=7'h01, status 00, nerr 0, cnt_clean=1.
- Single error: 15'h01D5 (bit 2 flipped) → out_codeword=15'h01D1, out_data=7'h01, status 01, nerr 1, cnt_corr=1.
- Double error: 15'h41D0 (bits 14 and 0) → out_codeword=15'h01D1, status 01, nerr 2. Then sweep all 105 two-bit patterns: 105 CORRECTED, 0 UNCORRECTABLE.
- Stub decoder forcing flag=1, vector=0 on input 15'h7FFF → status 10, out_codeword=15'h7FFF, cnt_uncorr=1, cnt_total=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_* stable; in_ready=0; dec_codeword unchanged.
  - Then out_ready=1 with in_valid=1 → same-edge accept; next out_valid exactly 4 cycles later.
- Clears and reset:
  - stats_clr on the capture edge → all counters 0 afterwards.
  - rst=0 for one edge mid-WAIT → out_valid never rises for that word; busy=0; counters 0.
